seg7_display_out: RTL and testbench

SEG7_DISPLAY_OUT -- requirements
Module: seg7_display_out

---
 rtl/seg7_display_out.sv | 194 +++++++++++++++++++
 tb/tb_seg7_display_out.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_out.sv
// seg7_display_out: CPU-writable 8-digit multiplexed seven-segment driver.
//   Holds a 32-bit display register that is shown either as 8 hex nibbles or
//   as 8 BCD digits. A decimal write runs a 32-step serial shift-add-3
//   conversion and commits the low 8 digits atomically.
//
//   Optional feature: define SEG7_LZ_BLANK_EN to blank leading zeros of a
//   decimal-committed value (digit 0 always shown), ORed with the blank mask.
//
// Ports:
//   fpga_clk  in   sole clock, rising edge
//   fpga_rst  in   asynchronous active-low reset
//   io_wen    in   write strobe
//   io_addr   in   [1:0] 0 value, 1 mode, 2 blank mask, 3 reserved
//   io_wdata  in   [31:0] write data
//   io_ready  out  write can be accepted (low while converting)
//   seg_en    out  [7:0] active-low one-hot digit enable, bit 0 rightmost
//   seg_out   out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}
module seg7_display_out #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        io_wen,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic        io_ready,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ITER_W = 5;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(31);

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ITER_W-1:0]   iter_cnt;
  logic [31:0]         bin_sr;
  logic [31:0]         bcd_sr;
  logic [31:0]         bcd_adj;
  logic [31:0]         disp;
  logic                disp_dec;
  logic                mode;
  logic [7:0]          mask;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [2:0]          digit_idx;
  logic [7:0]          lz_blank;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                wr_acc;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // io_ready is high exactly when the FSM sits in IDLE.
  assign wr_acc = io_wen && io_ready;

  // Add-3 correction of every BCD digit >= 5 ahead of the next left shift.
  // Only 8 digits are kept: carries only move upward, so dropping the top
  // digits leaves value mod 10^8 intact.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < 8; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
      end
    end
  end

  // Register file, conversion FSM and atomic display commit.
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      state    <= IDLE;
      io_ready <= 1'b1;
      iter_cnt <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      disp     <= '0;
      disp_dec <= 1'b0;
      mode     <= 1'b0;
      mask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc) begin
            case (io_addr)
              2'd0: begin
                if (mode) begin
                  state    <= CONV;
                  io_ready <= 1'b0;
                  bin_sr   <= io_wdata;
                  bcd_sr   <= '0;
                  iter_cnt <= '0;
                end else begin
                  disp     <= io_wdata;
                  disp_dec <= 1'b0;
                end
              end
              2'd1:    mode <= io_wdata[0];
              2'd2:    mask <= io_wdata[7:0];
              default: ;
            endcase
          end
        end
        CONV: begin
          bcd_sr   <= {bcd_adj[30:0], bin_sr[31]};
          bin_sr   <= {bin_sr[30:0], 1'b0};
          iter_cnt <= iter_cnt + ITER_W'(1);
          if (iter_cnt == ITER_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          disp     <= bcd_sr;
          disp_dec <= 1'b1;
          io_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          io_ready <= 1'b1;
        end
      endcase
    end
  end

  // Leading-zero blank vector: digit i>0 is blanked when it and every digit
  // above it are zero on a decimal-committed value.
  always_comb begin
    logic lead;
    lz_blank = '0;
    lead     = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      lead        = lead && (disp[4*i +: 4] == 4'd0);
      lz_blank[i] = LZ_EN && disp_dec && lead;
    end
  end

  assign cur_nib   = disp[{digit_idx, 2'b00} +: 4];
  assign cur_blank = mask[digit_idx] | lz_blank[digit_idx];

  // Digit dwell counter and registered segment/enable outputs.
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      seg_en    <= 8'hFF;
      seg_out   <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      seg_en  <= ~(8'd1 << digit_idx);
      seg_out <= cur_blank ? 8'hFF : {1'b1, glyph(cur_nib)};
    end
  end

endmodule

// File: tb/tb_seg7_display_out.sv
// tb_seg7_display_out: scoreboard bench for seg7_display_out (SCAN_DIV=4).
//   A behavioural model advances once per rising edge and queues the
//   expected {seg_en, seg_out, io_ready}; a monitor pops and compares on
//   each falling edge. Stimulus is directed scenarios plus random writes.
module tb_seg7_display_out;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned CONV_CYCLES = 33;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        fpga_clk = 1'b0;
  logic        fpga_rst;
  logic        io_wen;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_ready;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  seg7_display_out #(.SCAN_DIV(SCAN_DIV)) dut (
    .fpga_clk (fpga_clk),
    .fpga_rst (fpga_rst),
    .io_wen   (io_wen),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_ready (io_ready),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [7:0] en;
    logic [7:0] out;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: what the display holds, in numeric terms.
  int unsigned m_cyc;
  bit          m_ready;
  int          m_busy;
  logic [31:0] m_pend;
  logic [31:0] m_hexv;
  longint      m_decv;
  bit          m_dec;
  bit          m_mode;
  logic [7:0]  m_mask;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    int  nib;
    bit  blank;
    if (m_dec) nib = int'((m_decv / pow10(d)) % 10);
    else       nib = int'((m_hexv >> (4 * d)) & 32'hF);
    blank = m_mask[d] || (LZ && m_dec && d > 0 && m_decv < pow10(d));
    return blank ? 8'hFF : GLYPH[nib];
  endfunction

  // Reference model: one step per rising edge, reset asynchronously.
  initial begin
    forever begin
      @(posedge fpga_clk or negedge fpga_rst);
      if (!fpga_rst) begin
        m_cyc = 0; m_ready = 1'b1; m_busy = 0; m_pend = '0;
        m_hexv = '0; m_decv = 0; m_dec = 1'b0; m_mode = 1'b0; m_mask = '0;
        exp_q.delete();
      end else begin
        exp_t e;
        int   d;
        d     = int'((m_cyc / SCAN_DIV) % 8);
        e.en  = ~(8'd1 << d);
        e.out = exp_seg(d);
        if (io_wen && m_ready && io_addr != 2'd3) begin
          case (io_addr)
            2'd0: begin
              if (m_mode) begin
                m_busy  = CONV_CYCLES;
                m_ready = 1'b0;
                m_pend  = io_wdata;
              end else begin
                m_hexv = io_wdata;
                m_dec  = 1'b0;
              end
            end
            2'd1:    m_mode = io_wdata[0];
            default: m_mask = io_wdata[7:0];
          endcase
        end else if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_decv  = longint'(m_pend) % 64'd100000000;
            m_dec   = 1'b1;
            m_ready = 1'b1;
          end
        end
        e.rdy = m_ready;
        exp_q.push_back(e);
        m_cyc++;
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge fpga_clk);
      if (!fpga_rst) begin
        check("rst_seg_en", seg_en, 8'hFF);
        check("rst_seg_out", seg_out, 8'hFF);
        check("rst_io_ready", {7'd0, io_ready}, 8'd1);
      end else if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("seg_en", seg_en, e.en);
        check("seg_out", seg_out, e.out);
        check("io_ready", {7'd0, io_ready}, {7'd0, e.rdy});
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge fpga_clk);
    io_wen   = 1'b1;
    io_addr  = a;
    io_wdata = d;
    @(negedge fpga_clk);
    io_wen   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge fpga_clk);
  endtask

  task automatic release_rst();
    @(negedge fpga_clk);
    #1 fpga_rst = 1'b1;
  endtask

  initial begin
    fpga_rst = 1'b0;
    io_wen   = 1'b0;
    io_addr  = 2'd0;
    io_wdata = '0;
    idle(3);
    release_rst();

    // Free-running scan of an all-zero display.
    idle(40);
    // Hex value.
    wr(2'd0, 32'h1234ABCD);
    idle(40);
    // Decimal conversion, old value held until commit.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd12345678);
    idle(50);
    // Max value, with a write attempted mid-conversion.
    wr(2'd0, 32'd4294967295);
    idle(5);
    wr(2'd0, 32'd5);
    idle(45);
    // Small value exercises leading zeros.
    wr(2'd0, 32'd42);
    idle(40);
    // Mode change keeps the committed formatting.
    wr(2'd1, 32'd0);
    idle(12);
    // Reserved address has no effect.
    wr(2'd3, 32'hFFFF_FFFF);
    idle(8);
    // Mask, then reset in the middle of a conversion.
    wr(2'd2, 32'h0F);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd777);
    idle(10);
    #2 fpga_rst = 1'b0;
    #1;
    check("async_seg_en", seg_en, 8'hFF);
    check("async_seg_out", seg_out, 8'hFF);
    check("async_io_ready", {7'd0, io_ready}, 8'd1);
    idle(3);
    release_rst();
    idle(40);

    // Random writes against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge fpga_clk);
      io_wen  = ($urandom_range(0, 3) == 0);
      io_addr = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       io_wdata = 32'($urandom_range(0, 999));
        1:       io_wdata = 32'd0;
        default: io_wdata = $urandom;
      endcase
    end
    @(negedge fpga_clk);
    io_wen = 1'b0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
